// File: rtl/tb_run_sequencer.sv
// -----------------------------------------------------------------------------
// tb_run_sequencer
//   Run controller placed between the bench clock/reset and the unit under
//   test. It holds the UUT in reset for a fixed number of cycles, releases it
//   for one settle cycle, then enables the UUT and runs a watchdog. It latches
//   the pass / fail / timeout outcome so the bench can poll a single done flag.
//
// Ports
//   clk          in   1      bench clock, all logic on the rising edge
//   rst_n        in   1      synchronous active-low reset
//   start        in   1      pulse, begins a sequence (IDLE or DONE only)
//   abort        in   1      ends an active sequence with a fail result
//   uut_done     in   1      UUT reports test complete (used in RUN only)
//   uut_fail     in   1      UUT failure flag, qualified by uut_done
//   uut_rst      out  1      reset to the UUT, active level = RPOLARITY
//   uut_en       out  1      UUT run enable
//   busy         out  1      high while in RESET, SETTLE or RUN
//   done         out  1      high in DONE, held until start or rst_n
//   pass         out  1      valid with done: UUT finished without failure
//   timeout      out  1      valid with done: watchdog expired
//   cycle_count  out  CNT_W  RUN cycles consumed, frozen in DONE
// -----------------------------------------------------------------------------
module tb_run_sequencer #(
  parameter int unsigned RST_CYCLES = 2,
  parameter logic        RPOLARITY  = 1'b0,
  parameter int unsigned TIMEOUT    = 1000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             uut_done,
  input  logic             uut_fail,
  output logic             uut_rst,
  output logic             uut_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RESET  = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Reset-hold counter only needs to reach RST_CYCLES-1.
  localparam int unsigned      RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic             WD_EN   = (TIMEOUT != 0);

  state_t          r_state;
  logic [RC_W-1:0] r_rst_cnt;

  logic [CNT_W-1:0] w_cnt_next;
  logic             w_wd_hit;
  logic             w_launch;
  logic             w_abort;

  // Next RUN count (saturating), watchdog expiry, and qualified start/abort.
  always_comb begin
    w_cnt_next = r_cycle_count_hold();
    w_wd_hit   = 1'b0;
    w_launch   = 1'b0;
    w_abort    = 1'b0;

    // Saturation only matters with the watchdog off; with it on the count
    // stops at TIMEOUT long before wrapping.
    if (&cycle_count) begin
      w_cnt_next = cycle_count;
    end else begin
      w_cnt_next = cycle_count + CNT_W'(1);
    end

    if (WD_EN && (w_cnt_next == TO_VAL)) begin
      w_wd_hit = 1'b1;
    end else begin
      w_wd_hit = 1'b0;
    end

    // start is honoured only when no sequence is active; it takes priority
    // over abort in DONE because abort is ignored there anyway.
    if ((r_state == S_IDLE) || (r_state == S_DONE)) begin
      w_launch = start;
      w_abort  = 1'b0;
    end else begin
      w_launch = 1'b0;
      w_abort  = abort;
    end
  end

  // Current count, used as the default for the next-count computation.
  function automatic logic [CNT_W-1:0] r_cycle_count_hold();
    return cycle_count;
  endfunction

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rst_cnt   <= '0;
      uut_rst     <= RPOLARITY;
      uut_en      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else if (w_launch) begin
      // Fresh sequence: clear the previous result and re-assert UUT reset.
      r_state     <= S_RESET;
      r_rst_cnt   <= '0;
      uut_rst     <= RPOLARITY;
      uut_en      <= 1'b0;
      busy        <= 1'b1;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else if (w_abort) begin
      // Abort beats uut_done; a RUN cycle in which abort arrives still counts.
      if (r_state == S_RUN) begin
        cycle_count <= w_cnt_next;
      end else begin
        cycle_count <= cycle_count;
      end
      r_state <= S_DONE;
      uut_rst <= ~RPOLARITY;
      uut_en  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b1;
      pass    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          uut_rst <= RPOLARITY;
          uut_en  <= 1'b0;
        end

        S_RESET: begin
          if (r_rst_cnt == RC_LAST) begin
            r_state <= S_SETTLE;
            uut_rst <= ~RPOLARITY;
          end else begin
            r_rst_cnt <= r_rst_cnt + RC_W'(1);
          end
        end

        S_SETTLE: begin
          r_state <= S_RUN;
          uut_en  <= 1'b1;
        end

        S_RUN: begin
          cycle_count <= w_cnt_next;
          // uut_done outranks a watchdog expiry in the same cycle.
          if (uut_done) begin
            r_state <= S_DONE;
            uut_en  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= ~uut_fail;
            timeout <= 1'b0;
          end else if (w_wd_hit) begin
            r_state <= S_DONE;
            uut_en  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
            timeout <= 1'b1;
          end else begin
            r_state <= S_RUN;
          end
        end

        S_DONE: begin
          // UUT stays out of reset so its final state remains observable.
          uut_rst <= ~RPOLARITY;
          uut_en  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          uut_rst <= RPOLARITY;
          uut_en  <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          pass    <= 1'b0;
          timeout <= 1'b0;
        end
      endcase
    end
  end

endmodule
